// File: rtl/uart_bus_sched_pkg.sv
// Shared encodings for the UART bus scheduler: FSM states, peripheral
// register addresses and status-bit positions.
package uart_bus_sched_pkg;

    typedef enum logic [2:0] {
        POLL  = 3'd0,
        STAT  = 3'd1,
        RXRD  = 3'd2,
        RXCAP = 3'd3,
        TXWR  = 3'd4,
        GUARD = 3'd5
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;

    localparam int ST_TXBUSY = 0;
    localparam int ST_RXFULL = 1;

endpackage

// File: rtl/uart_bus_sched_rr_arbiter.sv
// Round-robin first-valid search over NREQ requesters. The pointer names the
// requester with highest priority and moves past the winner on each accept.
module uart_bus_sched_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic            accept,
    output logic [PW-1:0]   grant,
    output logic            any,
    output logic [NREQ-1:0] grant_onehot
);

    logic [PW-1:0] rr_ptr_reg;
    int            idx;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % NREQ;
            if (req_valid[idx]) begin
                grant = PW'(idx);
                any   = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = any && (grant == PW'(gi));
        end
    endgenerate

    // Advance the priority pointer just past the requester that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (accept && any) begin
            rr_ptr_reg <= PW'((int'(grant) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/uart_bus_sched.sv
// Owns the UART register port: polls status, drains RX bytes to one consumer
// and writes TX bytes from NREQ requesters in round-robin order.
module uart_bus_sched
    import uart_bus_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int TX_GUARD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rx_valid,
    output logic [7:0]        rx_data,
    output logic              u_cs,
    output logic              u_we,
    output logic [1:0]        u_addr,
    output logic [7:0]        u_din,
    input  logic [7:0]        u_dout,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(TX_GUARD + 1);

    state_t          state_reg;
    logic [GW-1:0]   guard_reg;
    logic [7:0]      rx_data_reg;
    logic [PW-1:0]   grant;
    logic            grant_any;
    logic [NREQ-1:0] grant_onehot;

    // The grant is re-evaluated live in TXWR, so a requester that drops
    // req_valid early is simply skipped.
    uart_bus_sched_rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .accept       (state_reg == TXWR),
        .grant        (grant),
        .any          (grant_any),
        .grant_onehot (grant_onehot)
    );

    // Moore decode of the peripheral port and handshakes from the state.
    always_comb begin
        u_cs      = 1'b0;
        u_we      = 1'b0;
        u_addr    = ADDR_DATA;
        u_din     = 8'h00;
        req_ready = '0;
        rx_valid  = 1'b0;
        rx_data   = rx_data_reg;
        busy      = 1'b1;
        case (state_reg)
            POLL: begin
                u_cs   = 1'b1;
                u_addr = ADDR_STATUS;
                busy   = 1'b0;
            end
            STAT: begin
                u_addr = ADDR_STATUS;
                busy   = 1'b0;
            end
            RXRD: begin
                u_cs = 1'b1;
            end
            RXCAP: begin
                // Read data arrives this cycle; show it immediately with the pulse.
                rx_valid = 1'b1;
                rx_data  = u_dout;
            end
            TXWR: begin
                if (grant_any) begin
                    u_cs      = 1'b1;
                    u_we      = 1'b1;
                    u_din     = req_data[int'(grant)*8 +: 8];
                    req_ready = grant_onehot;
                end
            end
            default: begin
            end
        endcase
    end

    // Control FSM: RX drain has priority over TX; guard delay after each write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= POLL;
            guard_reg   <= '0;
            rx_data_reg <= 8'h00;
        end else begin
            case (state_reg)
                POLL: state_reg <= STAT;
                STAT: begin
                    if (u_dout[ST_RXFULL]) begin
                        state_reg <= RXRD;
                    end else if (!u_dout[ST_TXBUSY] && grant_any) begin
                        state_reg <= TXWR;
                    end else begin
                        state_reg <= POLL;
                    end
                end
                RXRD: state_reg <= RXCAP;
                RXCAP: begin
                    rx_data_reg <= u_dout;
                    state_reg   <= POLL;
                end
                TXWR: begin
                    if (grant_any) begin
                        guard_reg <= GW'(TX_GUARD - 1);
                        state_reg <= GUARD;
                    end else begin
                        state_reg <= POLL;
                    end
                end
                GUARD: begin
                    if (guard_reg == '0) begin
                        state_reg <= POLL;
                    end else begin
                        guard_reg <= guard_reg - GW'(1);
                    end
                end
                default: state_reg <= POLL;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_sched.sv
// Directed bench for uart_bus_sched with a small UART register model,
// byte-queue requesters and logs of writes, grants and received bytes.
module tb_uart_bus_sched;

    localparam int NREQ = 2;

    typedef struct {
        logic [NREQ-1:0] ready;
        logic [7:0]      din;
    } wr_vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              u_cs;
    logic              u_we;
    logic [1:0]        u_addr;
    logic [7:0]        u_din;
    logic [7:0]        u_dout = 8'h00;
    logic              busy;

    uart_bus_sched #(.NREQ(NREQ), .TX_GUARD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .u_cs      (u_cs),
        .u_we      (u_we),
        .u_addr    (u_addr),
        .u_din     (u_din),
        .u_dout    (u_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Peripheral and requester model state
    logic       tx_busy = 1'b0;
    int         rx_supplied = 0;
    int         rx_taken = 0;
    logic [7:0] rx_mem [64];
    logic [7:0] tx_src [NREQ][64];
    int         tx_cnt [NREQ] = '{default: 0};
    int         tx_idx [NREQ] = '{default: 0};

    // Logs
    logic [7:0]      wr_log [64];
    logic [NREQ-1:0] rdy_log [64];
    logic [7:0]      rx_log [64];
    int wr_cnt = 0;
    int rdy_cnt = 0;
    int rx_cnt = 0;
    int rd_cnt = 0;

    int n_checks = 0;
    int n_err = 0;

    // Requesters present the head of their queue and hold it until accepted.
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = tx_idx[i] < tx_cnt[i];
            req_data[8*i +: 8] = tx_src[i][tx_idx[i] % 64];
        end
    end

    // Registered-read UART register file plus transaction logging.
    always @(posedge clk) begin
        if (u_cs && !u_we) begin
            if (u_addr == 2'b01) begin
                u_dout <= {6'b0, rx_supplied != rx_taken, tx_busy};
            end else begin
                u_dout <= rx_mem[rx_taken % 64];
                if (rx_supplied != rx_taken) rx_taken <= rx_taken + 1;
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (!rst && u_cs && u_we && u_addr == 2'b00) begin
            wr_log[wr_cnt % 64] <= u_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (!rst && req_ready != '0) begin
            rdy_log[rdy_cnt % 64] <= req_ready;
            rdy_cnt <= rdy_cnt + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) tx_idx[i] <= tx_idx[i] + 1;
            end
        end
        if (!rst && rx_valid) begin
            rx_log[rx_cnt % 64] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: %0h", name, act);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_vec_t rr_vec [5];
        int cnt_same, cnt_we, cnt_rdy, cnt_notbusy, cnt_cs0;
        int rd0, guard;
        logic prev_cs;
        bit seen;

        rr_vec[0] = '{ready: 2'b01, din: 8'h77};
        rr_vec[1] = '{ready: 2'b10, din: 8'h20};
        rr_vec[2] = '{ready: 2'b01, din: 8'h10};
        rr_vec[3] = '{ready: 2'b10, din: 8'h21};
        rr_vec[4] = '{ready: 2'b01, din: 8'h11};

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("reset_we", int'(u_we), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_req_ready", int'(req_ready), 0);
        chk("reset_rx_data", int'(rx_data), 8'h00);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        chk("reset_poll", int'({u_cs, u_addr}), 3'b101);

        // ---- single TX byte, best-case latency and guard length
        tx_src[0][0] = 8'h41;
        tx_cnt[0] = 1;
        @(negedge clk);
        chk("stat_no_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("txwr_bus", int'({u_cs, u_we, u_addr, u_din}), int'({1'b1, 1'b1, 2'b00, 8'h41}));
        chk("txwr_ready", int'(req_ready), 2'b01);
        chk("txwr_busy", int'(busy), 1);
        cnt_cs0 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (!u_cs && busy) cnt_cs0++;
        end
        chk("guard_cycles", cnt_cs0, 4);
        @(negedge clk);
        chk("guard_then_poll", int'({u_cs, u_addr}), 3'b101);
        chk("tx1_wr_log", int'(wr_log[0]), 8'h41);

        // ---- single RX byte
        rd0 = rd_cnt;
        rx_mem[0] = 8'h5A;
        rx_supplied = 1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (rx_valid) seen = 1;
        end
        chk("rx_seen", int'(seen), 1);
        chk("rx_data_pulse", int'(rx_data), 8'h5A);
        repeat (6) @(negedge clk);
        chk("rx_data_hold", int'(rx_data), 8'h5A);
        chk("rx_once", rx_cnt, 1);
        chk("rx_one_read", rd_cnt - rd0, 1);

        // ---- reset during TXWR aborts the write
        tx_src[0][1] = 8'h77;
        tx_cnt[0] = 2;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (u_we) seen = 1;
        end
        chk("abort_reach_txwr", int'(seen), 1);
        tx_busy = 1'b1;
        rst = 1'b1;
        #1;
        chk("abort_we", int'(u_we), 0);
        chk("abort_ready", int'(req_ready), 0);
        chk("abort_rx_valid", int'(rx_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_poll", int'({u_cs, u_addr}), 3'b101);
        chk("abort_no_write", wr_cnt, 1);
        chk("abort_still_pending", tx_idx[0], 1);

        // ---- busy + RX with both requesters: RX first, then round-robin
        rx_mem[1] = 8'h33;
        rx_supplied = 2;
        tx_src[0][2] = 8'h10;
        tx_src[0][3] = 8'h11;
        tx_cnt[0] = 4;
        tx_src[1][0] = 8'h20;
        tx_src[1][1] = 8'h21;
        tx_cnt[1] = 2;
        for (int c = 0; c < 40 && rx_cnt < 2; c++) @(negedge clk);
        chk("rr_rx_byte", int'(rx_log[1]), 8'h33);
        repeat (10) @(negedge clk);
        chk("rr_no_write_busy", wr_cnt, 1);
        tx_busy = 1'b0;
        for (int c = 0; c < 200 && wr_cnt < 6; c++) @(negedge clk);
        chk("rr_write_count", wr_cnt, 6);
        for (int k = 0; k < 5; k++) begin
            $display("rr txn %0d: ready=%b din=%h", k, rdy_log[1+k], wr_log[1+k]);
            chk($sformatf("rr_ready_%0d", k), int'(rdy_log[1+k]), int'(rr_vec[k].ready));
            chk($sformatf("rr_din_%0d", k), int'(wr_log[1+k]), int'(rr_vec[k].din));
        end

        // ---- TX busy held: no writes, POLL/STAT alternation
        tx_busy = 1'b1;
        tx_src[0][4] = 8'h55;
        tx_cnt[0] = 5;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (u_cs && u_addr == 2'b01) seen = 1;
        end
        chk("busy_reach_poll", int'(seen), 1);
        cnt_same = 0; cnt_we = 0; cnt_rdy = 0; cnt_notbusy = 0;
        for (int c = 0; c < 100; c++) begin
            prev_cs = u_cs;
            @(negedge clk);
            if (u_cs == prev_cs) cnt_same++;
            if (u_we) cnt_we++;
            if (req_ready != '0) cnt_rdy++;
            if (!busy) cnt_notbusy++;
        end
        chk("busy_alternate", cnt_same, 0);
        chk("busy_no_we", cnt_we, 0);
        chk("busy_no_ready", cnt_rdy, 0);
        chk("busy_poll_stat_only", cnt_notbusy, 100);
        tx_busy = 1'b0;
        for (int c = 0; c < 40 && wr_cnt < 7; c++) @(negedge clk);
        chk("busy_release_write", int'(wr_log[6]), 8'h55);

        // ---- interleaved RX and TX traffic, no loss or duplication
        for (int k = 0; k < 4; k++) begin
            rx_mem[2+k] = 8'hA0 + 8'(k);
            tx_src[1][2+k] = 8'hB0 + 8'(k);
        end
        rx_supplied = 3;
        tx_cnt[1] = 6;
        guard = 0;
        while (guard < 400 && !(rx_cnt == 6 && wr_cnt == 11)) begin
            @(negedge clk);
            if (u_we && rx_supplied < 6) rx_supplied = rx_supplied + 1;
            guard++;
        end
        repeat (30) @(negedge clk);
        chk("mix_rx_count", rx_cnt, 6);
        chk("mix_wr_count", wr_cnt, 11);
        for (int k = 0; k < 4; k++) begin
            $display("mix txn %0d: rx=%h wr=%h ready=%b", k, rx_log[2+k], wr_log[7+k], rdy_log[7+k]);
            chk($sformatf("mix_rx_%0d", k), int'(rx_log[2+k]), 8'hA0 + k);
            chk($sformatf("mix_wr_%0d", k), int'(wr_log[7+k]), 8'hB0 + k);
            chk($sformatf("mix_ready_%0d", k), int'(rdy_log[7+k]), 2'b10);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
